// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes, MIPS opcode/funct constants and decoded-control struct
// Shared by the ALU control decoder and the ID/EX register stage.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

  typedef enum logic [1:0] {
    A_RS    = 2'd0,
    A_SHAMT = 2'd1,
    A_LUI16 = 2'd2
  } a_sel_e;

  typedef enum logic [1:0] {
    B_RT   = 2'd0,
    B_SEXT = 2'd1,
    B_ZEXT = 2'd2
  } b_sel_e;

  typedef enum logic {
    DST_RT = 1'b0,
    DST_RD = 1'b1
  } dst_sel_e;

  typedef struct packed {
    logic [3:0] alu_control;
    a_sel_e     a_sel;
    b_sel_e     b_sel;
    dst_sel_e   dst_sel;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch_eq;
    logic       illegal;
  } ctrl_t;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// rtl/alu_ctrl_dec.sv - combinational MIPS opcode/funct to ALU control and operand-select decode
// VAR_SHIFT_EN adds SLLV/SRLV; without it those functs decode as illegal.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  always_comb begin
    // Unsupported encodings fall through with ADD on rs/rt and no side effects.
    ctrl.alu_control = ALU_ADD;
    ctrl.a_sel       = A_RS;
    ctrl.b_sel       = B_RT;
    ctrl.dst_sel     = DST_RT;
    ctrl.reg_write   = 1'b0;
    ctrl.mem_read    = 1'b0;
    ctrl.mem_write   = 1'b0;
    ctrl.branch_eq   = 1'b0;
    ctrl.illegal     = 1'b1;

    case (opcode)
      OP_RTYPE: begin
        ctrl.dst_sel   = DST_RD;
        ctrl.illegal   = 1'b0;
        ctrl.reg_write = 1'b1;
        case (funct)
          F_ADD, F_ADDU: ctrl.alu_control = ALU_ADD;
          F_SUB, F_SUBU: ctrl.alu_control = ALU_SUB;
          F_AND:         ctrl.alu_control = ALU_AND;
          F_OR:          ctrl.alu_control = ALU_OR;
          F_XOR:         ctrl.alu_control = ALU_XOR;
          F_NOR:         ctrl.alu_control = ALU_NOR;
          F_SLT:         ctrl.alu_control = ALU_SLT;
          F_SLL: begin
            ctrl.alu_control = ALU_SLL;
            ctrl.a_sel       = A_SHAMT;
          end
          F_SRL: begin
            ctrl.alu_control = ALU_SRL;
            ctrl.a_sel       = A_SHAMT;
          end
`ifdef VAR_SHIFT_EN
          F_SLLV:        ctrl.alu_control = ALU_SLL;
          F_SRLV:        ctrl.alu_control = ALU_SRL;
`endif
          default: begin
            ctrl.illegal   = 1'b1;
            ctrl.reg_write = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl.b_sel     = B_SEXT;
        ctrl.reg_write = 1'b1;
        ctrl.illegal   = 1'b0;
      end
      OP_SLTI: begin
        ctrl.alu_control = ALU_SLT;
        ctrl.b_sel       = B_SEXT;
        ctrl.reg_write   = 1'b1;
        ctrl.illegal     = 1'b0;
      end
      OP_ANDI: begin
        ctrl.alu_control = ALU_AND;
        ctrl.b_sel       = B_ZEXT;
        ctrl.reg_write   = 1'b1;
        ctrl.illegal     = 1'b0;
      end
      OP_ORI: begin
        ctrl.alu_control = ALU_OR;
        ctrl.b_sel       = B_ZEXT;
        ctrl.reg_write   = 1'b1;
        ctrl.illegal     = 1'b0;
      end
      OP_XORI: begin
        ctrl.alu_control = ALU_XOR;
        ctrl.b_sel       = B_ZEXT;
        ctrl.reg_write   = 1'b1;
        ctrl.illegal     = 1'b0;
      end
      OP_LW: begin
        ctrl.b_sel     = B_SEXT;
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.illegal   = 1'b0;
      end
      OP_SW: begin
        ctrl.b_sel     = B_SEXT;
        ctrl.mem_write = 1'b1;
        ctrl.illegal   = 1'b0;
      end
      OP_BEQ: begin
        ctrl.alu_control = ALU_SUB;
        ctrl.branch_eq   = 1'b1;
        ctrl.illegal     = 1'b0;
      end
      OP_LUI: begin
        // lui is executed as zext(imm) << 16 on the shared shifter.
        ctrl.alu_control = ALU_SLL;
        ctrl.a_sel       = A_LUI16;
        ctrl.b_sel       = B_ZEXT;
        ctrl.reg_write   = 1'b1;
        ctrl.illegal     = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_decode_idex.sv
// rtl/alu_decode_idex.sv - MIPS ALU decode plus ID/EX pipeline register with stall, flush, illegal counter
// Optional VAR_SHIFT_EN enables SLLV/SRLV decode.
module alu_decode_idex
  import alu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  input  logic             stall,
  input  logic             flush,
  output logic             ex_valid,
  output logic [3:0]       ex_alu_control,
  output logic [31:0]      ex_op_a,
  output logic [31:0]      ex_op_b,
  output logic [4:0]       ex_dst_reg,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_branch_eq,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ctrl_t       dec;
  logic [31:0] id_op_a;
  logic [31:0] id_op_b;
  logic [4:0]  id_dst;
  logic        id_reg_write;
  logic        unused_rs_field;

  // rs arrives already forwarded, so its register index is not needed here.
  assign unused_rs_field = ^instr[25:21];

  alu_ctrl_dec u_ctrl_dec (
    .opcode (instr[31:26]),
    .funct  (instr[5:0]),
    .ctrl   (dec)
  );

  always_comb begin
    case (dec.a_sel)
      A_SHAMT: id_op_a = {27'd0, instr[10:6]};
      A_LUI16: id_op_a = 32'd16;
      default: id_op_a = rs_data;
    endcase
    case (dec.b_sel)
      B_SEXT:  id_op_b = sext16(instr[15:0]);
      B_ZEXT:  id_op_b = {16'd0, instr[15:0]};
      default: id_op_b = rt_data;
    endcase
    id_dst       = (dec.dst_sel == DST_RD) ? instr[15:11] : instr[20:16];
    id_reg_write = dec.reg_write && (id_dst != 5'd0);
  end

  logic             ex_valid_q, ex_valid_d;
  logic [3:0]       alu_control_q, alu_control_d;
  logic [31:0]      op_a_q, op_a_d;
  logic [31:0]      op_b_q, op_b_d;
  logic [4:0]       dst_reg_q, dst_reg_d;
  logic             reg_write_q, reg_write_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic             branch_eq_q, branch_eq_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] illegal_count_q, illegal_count_d;

  always_comb begin
    ex_valid_d      = ex_valid_q;
    alu_control_d   = alu_control_q;
    op_a_d          = op_a_q;
    op_b_d          = op_b_q;
    dst_reg_d       = dst_reg_q;
    reg_write_d     = reg_write_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    branch_eq_d     = branch_eq_q;
    illegal_d       = illegal_q;
    illegal_count_d = illegal_count_q;

    // Flush beats stall; an empty ID slot also inserts a bubble.
    if (flush || (!stall && !in_valid)) begin
      ex_valid_d    = 1'b0;
      alu_control_d = 4'd0;
      op_a_d        = 32'd0;
      op_b_d        = 32'd0;
      dst_reg_d     = 5'd0;
      reg_write_d   = 1'b0;
      mem_read_d    = 1'b0;
      mem_write_d   = 1'b0;
      branch_eq_d   = 1'b0;
      illegal_d     = 1'b0;
    end else if (!stall) begin
      ex_valid_d    = 1'b1;
      alu_control_d = dec.alu_control;
      op_a_d        = id_op_a;
      op_b_d        = id_op_b;
      dst_reg_d     = id_dst;
      reg_write_d   = id_reg_write;
      mem_read_d    = dec.mem_read;
      mem_write_d   = dec.mem_write;
      branch_eq_d   = dec.branch_eq;
      illegal_d     = dec.illegal;
      if (dec.illegal && (illegal_count_q != CNT_MAX)) begin
        illegal_count_d = illegal_count_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q      <= 1'b0;
      alu_control_q   <= 4'd0;
      op_a_q          <= 32'd0;
      op_b_q          <= 32'd0;
      dst_reg_q       <= 5'd0;
      reg_write_q     <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      branch_eq_q     <= 1'b0;
      illegal_q       <= 1'b0;
      illegal_count_q <= '0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      alu_control_q   <= alu_control_d;
      op_a_q          <= op_a_d;
      op_b_q          <= op_b_d;
      dst_reg_q       <= dst_reg_d;
      reg_write_q     <= reg_write_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      branch_eq_q     <= branch_eq_d;
      illegal_q       <= illegal_d;
      illegal_count_q <= illegal_count_d;
    end
  end

  assign ex_valid       = ex_valid_q;
  assign ex_alu_control = alu_control_q;
  assign ex_op_a        = op_a_q;
  assign ex_op_b        = op_b_q;
  assign ex_dst_reg     = dst_reg_q;
  assign ex_reg_write   = reg_write_q;
  assign ex_mem_read    = mem_read_q;
  assign ex_mem_write   = mem_write_q;
  assign ex_branch_eq   = branch_eq_q;
  assign ex_illegal     = illegal_q;
  assign illegal_count  = illegal_count_q;

endmodule

// File: tb/tb_alu_decode_idex.sv
// tb/tb_alu_decode_idex.sv - directed and randomized bench for alu_decode_idex against an instruction-semantics model
// Build with or without VAR_SHIFT_EN to match the design.
module tb_alu_decode_idex;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, in_valid, stall, flush;
  logic [31:0]      instr, rs_data, rt_data;
  logic             ex_valid;
  logic [3:0]       ex_alu_control;
  logic [31:0]      ex_op_a, ex_op_b;
  logic [4:0]       ex_dst_reg;
  logic             ex_reg_write, ex_mem_read, ex_mem_write, ex_branch_eq, ex_illegal;
  logic [CNT_W-1:0] illegal_count;

  alu_decode_idex #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .instr          (instr),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .stall          (stall),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_alu_control (ex_alu_control),
    .ex_op_a        (ex_op_a),
    .ex_op_b        (ex_op_b),
    .ex_dst_reg     (ex_dst_reg),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_branch_eq   (ex_branch_eq),
    .ex_illegal     (ex_illegal),
    .illegal_count  (illegal_count)
  );

  typedef struct packed {
    logic        valid;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  dst;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        ill;
  } exp_t;

  int    tests = 0;
  int    fails = 0;
  exp_t  exp_s;
  int    exp_cnt;
  string lbl;

  function automatic logic [31:0] slt32(input logic [31:0] a, input logic [31:0] b);
    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
  endfunction

  // What an EX-stage ALU computes from the registered control and operands.
  function automatic logic [31:0] alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a ^ b;
      4'd4:    return b << a[4:0];
      4'd5:    return b >> a[4:0];
      4'd6:    return a - b;
      4'd7:    return slt32(a, b);
      4'd12:   return ~(a | b);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic exp_t mk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] d, input logic w, input logic [31:0] r);
    exp_t e;
    e       = '0;
    e.valid = 1'b1;
    e.ctrl  = c;
    e.a     = a;
    e.b     = b;
    e.dst   = d;
    e.rw    = w && (d != 5'd0);
    e.res   = r;
    return e;
  endfunction

  // Instruction semantics: what each MIPS instruction should present to EX and what it computes.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    exp_t        e;
    logic [5:0]  op, fn;
    logic [4:0]  rtf, rdf, sh;
    logic [31:0] se, ze;
    op  = ins[31:26];
    fn  = ins[5:0];
    rtf = ins[20:16];
    rdf = ins[15:11];
    sh  = ins[10:6];
    se  = {{16{ins[15]}}, ins[15:0]};
    ze  = {16'd0, ins[15:0]};
    e       = '0;
    e.valid = 1'b1;
    e.ctrl  = 4'd2;
    e.a     = rs;
    e.b     = rt;
    e.ill   = 1'b1;
    case (op)
      6'h00: begin
        case (fn)
          6'h20, 6'h21: e = mk(4'd2, rs, rt, rdf, 1'b1, rs + rt);
          6'h22, 6'h23: e = mk(4'd6, rs, rt, rdf, 1'b1, rs - rt);
          6'h24: e = mk(4'd0, rs, rt, rdf, 1'b1, rs & rt);
          6'h25: e = mk(4'd1, rs, rt, rdf, 1'b1, rs | rt);
          6'h26: e = mk(4'd3, rs, rt, rdf, 1'b1, rs ^ rt);
          6'h27: e = mk(4'd12, rs, rt, rdf, 1'b1, ~(rs | rt));
          6'h2A: e = mk(4'd7, rs, rt, rdf, 1'b1, slt32(rs, rt));
          6'h00: e = mk(4'd4, {27'd0, sh}, rt, rdf, 1'b1, rt << sh);
          6'h02: e = mk(4'd5, {27'd0, sh}, rt, rdf, 1'b1, rt >> sh);
`ifdef VAR_SHIFT_EN
          6'h04: e = mk(4'd4, rs, rt, rdf, 1'b1, rt << rs[4:0]);
          6'h06: e = mk(4'd5, rs, rt, rdf, 1'b1, rt >> rs[4:0]);
`endif
          default: ;
        endcase
      end
      6'h08, 6'h09: e = mk(4'd2, rs, se, rtf, 1'b1, rs + se);
      6'h0A: e = mk(4'd7, rs, se, rtf, 1'b1, slt32(rs, se));
      6'h0C: e = mk(4'd0, rs, ze, rtf, 1'b1, rs & ze);
      6'h0D: e = mk(4'd1, rs, ze, rtf, 1'b1, rs | ze);
      6'h0E: e = mk(4'd3, rs, ze, rtf, 1'b1, rs ^ ze);
      6'h0F: e = mk(4'd4, 32'd16, ze, rtf, 1'b1, {ins[15:0], 16'd0});
      6'h23: begin
        e    = mk(4'd2, rs, se, rtf, 1'b1, rs + se);
        e.mr = 1'b1;
      end
      6'h2B: begin
        e    = mk(4'd2, rs, se, rtf, 1'b0, rs + se);
        e.mw = 1'b1;
      end
      6'h04: begin
        e    = mk(4'd6, rs, rt, rtf, 1'b0, rs - rt);
        e.br = 1'b1;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 15))
      0, 1, 2, 3, 4: begin
        w[31:26] = 6'h00;
        case ($urandom_range(0, 15))
          0:  w[5:0] = 6'h20;
          1:  w[5:0] = 6'h21;
          2:  w[5:0] = 6'h22;
          3:  w[5:0] = 6'h23;
          4:  w[5:0] = 6'h24;
          5:  w[5:0] = 6'h25;
          6:  w[5:0] = 6'h26;
          7:  w[5:0] = 6'h27;
          8:  w[5:0] = 6'h2A;
          9:  w[5:0] = 6'h00;
          10: w[5:0] = 6'h02;
          11: w[5:0] = 6'h04;
          12: w[5:0] = 6'h06;
          default: ;
        endcase
      end
      5:  w[31:26] = 6'h08;
      6:  w[31:26] = 6'h09;
      7:  w[31:26] = 6'h0A;
      8:  w[31:26] = 6'h0C;
      9:  w[31:26] = 6'h0D;
      10: w[31:26] = 6'h0E;
      11: w[31:26] = 6'h0F;
      12: w[31:26] = 6'h23;
      13: w[31:26] = 6'h2B;
      14: w[31:26] = 6'h04;
      default: ;
    endcase
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s.%s observed=%0h expected=%0h", lbl, tag, obs, expv);
    end
  endtask

  // Apply one clock of inputs, advance the reference pipeline register, sample 1 time unit after the edge.
  task automatic step(input logic r, input logic fl, input logic st, input logic iv,
                      input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    exp_t d;
    rst      = r;
    flush    = fl;
    stall    = st;
    in_valid = iv;
    instr    = ins;
    rs_data  = rs;
    rt_data  = rt;
    d = ref_decode(ins, rs, rt);
    if (r) begin
      exp_s   = '0;
      exp_cnt = 0;
    end else if (fl) begin
      exp_s = '0;
    end else if (!st) begin
      if (iv) begin
        exp_s = d;
        if (d.ill && exp_cnt < CNT_MAX) exp_cnt++;
      end else begin
        exp_s = '0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all();
    chk("valid", {31'd0, ex_valid}, {31'd0, exp_s.valid});
    chk("ctrl", {28'd0, ex_alu_control}, {28'd0, exp_s.ctrl});
    chk("op_a", ex_op_a, exp_s.a);
    chk("op_b", ex_op_b, exp_s.b);
    chk("reg_write", {31'd0, ex_reg_write}, {31'd0, exp_s.rw});
    chk("mem_read", {31'd0, ex_mem_read}, {31'd0, exp_s.mr});
    chk("mem_write", {31'd0, ex_mem_write}, {31'd0, exp_s.mw});
    chk("branch_eq", {31'd0, ex_branch_eq}, {31'd0, exp_s.br});
    chk("illegal", {31'd0, ex_illegal}, {31'd0, exp_s.ill});
    chk("count", {{(32-CNT_W){1'b0}}, illegal_count}, exp_cnt[31:0]);
    if (!exp_s.ill) chk("dst", {27'd0, ex_dst_reg}, {27'd0, exp_s.dst});
    if (exp_s.valid && !exp_s.ill) chk("alu_result", alu(ex_alu_control, ex_op_a, ex_op_b), exp_s.res);
  endtask

  logic [31:0] w;
  int          pre_cnt;

  initial begin
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    instr = 32'd0; rs_data = 32'd0; rt_data = 32'd0;
    exp_s = '0; exp_cnt = 0;

    lbl = "reset";
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'd1, 32'd2);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'hFC00_0000, 32'd1, 32'd2);
    check_all();
    chk("rst_ctrl", {28'd0, ex_alu_control}, 32'd0);

    lbl = "add";
    step(1'b0, 1'b0, 1'b0, 1'b1, {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'd5, 32'd7);
    check_all();
    chk("ctrl_const", {28'd0, ex_alu_control}, 32'h2);
    chk("a_const", ex_op_a, 32'd5);
    chk("b_const", ex_op_b, 32'd7);
    chk("dst_const", {27'd0, ex_dst_reg}, 32'd3);
    chk("rw_const", {31'd0, ex_reg_write}, 32'd1);

    lbl = "lui";
    step(1'b0, 1'b0, 1'b0, 1'b1, {6'h0F, 5'd0, 5'd4, 16'h1234}, 32'hAAAA_AAAA, 32'h5555_5555);
    check_all();
    chk("ctrl_const", {28'd0, ex_alu_control}, 32'h4);
    chk("a_const", ex_op_a, 32'd16);
    chk("b_const", ex_op_b, 32'h0000_1234);
    chk("res_const", alu(ex_alu_control, ex_op_a, ex_op_b), 32'h1234_0000);

    lbl = "addi_neg";
    step(1'b0, 1'b0, 1'b0, 1'b1, {6'h08, 5'd1, 5'd2, 16'hFFFF}, 32'd9, 32'd0);
    check_all();
    chk("b_const", ex_op_b, 32'hFFFF_FFFF);

    lbl = "andi";
    step(1'b0, 1'b0, 1'b0, 1'b1, {6'h0C, 5'd1, 5'd2, 16'hFFFF}, 32'h1234_5678, 32'd0);
    check_all();
    chk("b_const", ex_op_b, 32'h0000_FFFF);

    lbl = "stall";
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, {6'h0F, 5'd0, 5'd9, 16'hBEEF}, 32'd1, 32'd2);
      check_all();
      chk("ctrl_hold", {28'd0, ex_alu_control}, 32'h0);
      chk("a_hold", ex_op_a, 32'h1234_5678);
      chk("b_hold", ex_op_b, 32'h0000_FFFF);
    end

    lbl = "stall_flush";
    step(1'b0, 1'b1, 1'b1, 1'b1, {6'h0F, 5'd0, 5'd9, 16'hBEEF}, 32'd1, 32'd2);
    check_all();
    chk("valid_const", {31'd0, ex_valid}, 32'd0);

    lbl = "nop";
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'd3, 32'd4);
    check_all();
    chk("valid_const", {31'd0, ex_valid}, 32'd1);
    chk("rw_const", {31'd0, ex_reg_write}, 32'd0);

    lbl = "sllv";
    pre_cnt = int'(illegal_count);
    step(1'b0, 1'b0, 1'b0, 1'b1, {6'h00, 5'd6, 5'd7, 5'd5, 5'd0, 6'h04}, 32'd3, 32'h0000_0011);
    check_all();
`ifdef VAR_SHIFT_EN
    chk("ctrl_const", {28'd0, ex_alu_control}, 32'h4);
    chk("a_const", ex_op_a, 32'd3);
`else
    chk("ill_const", {31'd0, ex_illegal}, 32'd1);
    chk("cnt_inc", {{(32-CNT_W){1'b0}}, illegal_count}, pre_cnt[31:0] + 32'd1);
`endif

    lbl = "idle";
    step(1'b0, 1'b0, 1'b0, 1'b0, {6'h08, 5'd1, 5'd2, 16'h0001}, 32'd1, 32'd1);
    check_all();

    lbl = "random";
    for (int i = 0; i < 500; i++) begin
      w = rand_instr();
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) != 0), w, $urandom(), $urandom());
      check_all();
    end

    lbl = "illegal_sat";
    for (int i = 0; i < 300; i++) begin
      w = $urandom();
      w[31:26] = 6'h3F;
      step(1'b0, 1'b0, 1'b0, 1'b1, w, $urandom(), $urandom());
      check_all();
    end
    chk("count_sat", {{(32-CNT_W){1'b0}}, illegal_count}, 32'd255);

    lbl = "reset_count";
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'hFC00_0000, 32'd0, 32'd0);
    check_all();
    chk("count_zero", {{(32-CNT_W){1'b0}}, illegal_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
